hms_timekeeper: RTL and testbench

HMS_TIMEKEEPER -- requirements
Module: hms_timekeeper

---
 rtl/hms_timekeeper.sv | 172 +++++++++++++++++
 tb/tb_hms_timekeeper.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_timekeeper.sv
// hms_timekeeper: seconds/minutes/hours timekeeper with a CLOCK/SETUP mode
// machine driven by three debounced switches. CLK_HZ cycles make one second.
// H24 selects 24-hour (0..23) or 12-hour (1..12 plus PM flag) hours.
//
//   state    | meaning
//   ST_CLOCK | prescaler running, time advances on each terminal count
//   ST_SETUP | prescaler held at 0, pos/inc switches edit the time fields
module hms_timekeeper #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter bit          H24    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic       o_mode,
  output logic [1:0] o_pos,
  output logic       o_sec_tick,
  output logic       o_day_tick
);

  typedef enum logic {ST_CLOCK = 1'b0, ST_SETUP = 1'b1} mode_e;

  localparam logic [31:0] TC_VAL   = 32'(CLK_HZ - 1);
  localparam logic [4:0]  HOUR_RST = H24 ? 5'd0 : 5'd12;
  localparam logic [1:0]  POS_SEC  = 2'd0;
  localparam logic [1:0]  POS_MIN  = 2'd1;
  localparam logic [1:0]  POS_HOUR = 2'd2;

  mode_e       mode_q, mode_d;
  logic [1:0]  pos_q, pos_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic [4:0]  hour_q, hour_d;
  logic        pm_q, pm_d;
  logic [31:0] pre_q, pre_d;
  logic        sec_tick_q, sec_tick_d;
  logic        day_tick_q, day_tick_d;
  logic        sw_mode_q, sw_pos_q, sw_inc_q;

  logic        mode_edge, pos_edge, inc_edge, tc;
  logic [4:0]  hour_nxt;
  logic        pm_nxt, day_wrap;

  assign mode_edge = i_sw_mode & ~sw_mode_q;
  assign pos_edge  = i_sw_pos  & ~sw_pos_q;
  assign inc_edge  = i_sw_inc  & ~sw_inc_q;
  assign tc        = (mode_q == ST_CLOCK) && (pre_q == TC_VAL);

  // Next hour value shared by the clock carry and the setup increment;
  // day_wrap marks the end-of-day transition (only used on a clock carry).
  always_comb begin
    hour_nxt = hour_q + 5'd1;
    pm_nxt   = pm_q;
    day_wrap = 1'b0;
    if (H24) begin
      pm_nxt = 1'b0;
      if (hour_q == 5'd23) begin
        hour_nxt = 5'd0;
        day_wrap = 1'b1;
      end
    end else begin
      if (hour_q == 5'd11) begin
        hour_nxt = 5'd12;
        pm_nxt   = ~pm_q;
        day_wrap = pm_q;
      end else if (hour_q == 5'd12) begin
        hour_nxt = 5'd1;
      end
    end
  end

  // Mode machine, field editing and time keeping with priority mode > pos > inc > TC.
  always_comb begin
    mode_d     = mode_q;
    pos_d      = pos_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    pm_d       = pm_q;
    pre_d      = 32'd0;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;
    if (mode_edge) begin
      // A TC landing on this cycle is dropped; prescaler restarts from 0.
      if (mode_q == ST_CLOCK) begin
        mode_d = ST_SETUP;
        pos_d  = POS_SEC;
      end else begin
        mode_d = ST_CLOCK;
      end
    end else if (mode_q == ST_SETUP) begin
      if (pos_edge) begin
        pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
      end else if (inc_edge) begin
        case (pos_q)
          POS_SEC:  sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          POS_MIN:  min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          POS_HOUR: begin
            hour_d = hour_nxt;
            pm_d   = pm_nxt;
          end
          default: ;
        endcase
      end
    end else begin
      pre_d = tc ? 32'd0 : pre_q + 32'd1;
      if (tc) begin
        sec_tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d      = 6'd0;
            hour_d     = hour_nxt;
            pm_d       = pm_nxt;
            day_tick_d = day_wrap;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end
  end

  // State, time, prescaler, tick and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= ST_CLOCK;
      pos_q      <= POS_SEC;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= HOUR_RST;
      pm_q       <= 1'b0;
      pre_q      <= 32'd0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      sw_mode_q  <= 1'b0;
      sw_pos_q   <= 1'b0;
      sw_inc_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pos_q      <= pos_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      pm_q       <= pm_d;
      pre_q      <= pre_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
      sw_mode_q  <= i_sw_mode;
      sw_pos_q   <= i_sw_pos;
      sw_inc_q   <= i_sw_inc;
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hour     = hour_q;
  assign o_pm       = pm_q;
  assign o_mode     = mode_q;
  assign o_pos      = pos_q;
  assign o_sec_tick = sec_tick_q;
  assign o_day_tick = day_tick_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Testbench for hms_timekeeper: index 0 is a 24-hour instance, index 1 a
// 12-hour instance, both with CLK_HZ=4. Inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.
module tb_hms_timekeeper;

  logic       clk;
  logic       rst_n;
  logic       sw_mode [2];
  logic       sw_pos  [2];
  logic       sw_inc  [2];
  logic [5:0] o_sec   [2];
  logic [5:0] o_min   [2];
  logic [4:0] o_hour  [2];
  logic       o_pm    [2];
  logic       o_mode  [2];
  logic [1:0] o_pos   [2];
  logic       o_stick [2];
  logic       o_dtick [2];
  logic       tick_seen [2];

  int checks   = 0;
  int failures = 0;

  hms_timekeeper #(.CLK_HZ(4), .H24(1'b1)) dut24 (
    .clk(clk), .rst_n(rst_n),
    .i_sw_mode(sw_mode[0]), .i_sw_pos(sw_pos[0]), .i_sw_inc(sw_inc[0]),
    .o_sec(o_sec[0]), .o_min(o_min[0]), .o_hour(o_hour[0]), .o_pm(o_pm[0]),
    .o_mode(o_mode[0]), .o_pos(o_pos[0]),
    .o_sec_tick(o_stick[0]), .o_day_tick(o_dtick[0])
  );

  hms_timekeeper #(.CLK_HZ(4), .H24(1'b0)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .i_sw_mode(sw_mode[1]), .i_sw_pos(sw_pos[1]), .i_sw_inc(sw_inc[1]),
    .o_sec(o_sec[1]), .o_min(o_min[1]), .o_hour(o_hour[1]), .o_pm(o_pm[1]),
    .o_mode(o_mode[1]), .o_pos(o_pos[1]),
    .o_sec_tick(o_stick[1]), .o_day_tick(o_dtick[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       m, p, i;
    logic       em;
    logic [1:0] ep;
    logic [5:0] es, emin;
    logic [4:0] eh;
    logic       est, edt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic m, p, i, em, input logic [1:0] ep,
                              input logic [5:0] es, emin, input logic [4:0] eh,
                              input logic est, edt);
    vec_t v;
    v.m = m; v.p = p; v.i = i; v.em = em; v.ep = ep;
    v.es = es; v.emin = emin; v.eh = eh; v.est = est; v.edt = edt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      if (o_stick[k] || o_dtick[k]) tick_seen[k] = 1'b1;
  endtask

  task automatic press(input int d, input int which, input int n);
    for (int k = 0; k < n; k++) begin
      case (which)
        0: sw_mode[d] = 1'b1;
        1: sw_pos[d]  = 1'b1;
        default: sw_inc[d] = 1'b1;
      endcase
      tick();
      sw_mode[d] = 1'b0;
      sw_pos[d]  = 1'b0;
      sw_inc[d]  = 1'b0;
      tick();
    end
  endtask

  task automatic wait_stick(input int d, input string name);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 12 && !ok; k++) begin
      tick();
      if (o_stick[d]) ok = 1'b1;
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sw_mode[k] = 1'b0; sw_pos[k] = 1'b0; sw_inc[k] = 1'b0;
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_time(input int d, input string name, input int h, input int m,
                            input int s, input logic pm);
    check({name, "_hour"}, 32'(o_hour[d]), 32'(h));
    check({name, "_min"},  32'(o_min[d]),  32'(m));
    check({name, "_sec"},  32'(o_sec[d]),  32'(s));
    check({name, "_pm"},   32'(o_pm[d]),   32'(pm));
  endtask

  initial begin
    logic [31:0] act, exp;
    int          tc_cyc;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sw_mode[k] = 1'b0; sw_pos[k] = 1'b0; sw_inc[k] = 1'b0; tick_seen[k] = 1'b0;
    end

    // Cycle vectors for the 24-hour instance, starting right after reset release.
    for (int r = 1; r <= 16; r++)
      add(0,0,0, 0,2'd0, 6'(r/4),6'd0,5'd0, (r%4 == 0),0);
    add(0,0,0, 0,2'd0, 6'd4,6'd0,5'd0, 0,0);  // 17
    add(1,0,0, 1,2'd0, 6'd4,6'd0,5'd0, 0,0);  // 18 enter SETUP
    add(1,0,1, 1,2'd0, 6'd5,6'd0,5'd0, 0,0);  // 19 inc sec
    add(1,0,1, 1,2'd0, 6'd5,6'd0,5'd0, 0,0);  // 20 held, no edge
    add(0,1,0, 1,2'd1, 6'd5,6'd0,5'd0, 0,0);  // 21 pos -> MIN
    add(0,1,1, 1,2'd1, 6'd5,6'd1,5'd0, 0,0);  // 22 inc min
    add(0,0,0, 1,2'd1, 6'd5,6'd1,5'd0, 0,0);  // 23
    add(0,1,1, 1,2'd2, 6'd5,6'd1,5'd0, 0,0);  // 24 pos beats inc
    add(0,0,0, 1,2'd2, 6'd5,6'd1,5'd0, 0,0);  // 25
    add(0,0,1, 1,2'd2, 6'd5,6'd1,5'd1, 0,0);  // 26 inc hour
    add(1,0,0, 0,2'd2, 6'd5,6'd1,5'd1, 0,0);  // 27 back to CLOCK
    add(0,0,0, 0,2'd2, 6'd5,6'd1,5'd1, 0,0);  // 28
    add(0,0,0, 0,2'd2, 6'd5,6'd1,5'd1, 0,0);  // 29
    add(0,0,0, 0,2'd2, 6'd5,6'd1,5'd1, 0,0);  // 30
    add(0,0,0, 0,2'd2, 6'd6,6'd1,5'd1, 1,0);  // 31 first TC after mode edge
    add(0,0,1, 0,2'd2, 6'd6,6'd1,5'd1, 0,0);  // 32 inc ignored in CLOCK
    add(0,1,0, 0,2'd2, 6'd6,6'd1,5'd1, 0,0);  // 33 pos ignored in CLOCK
    add(0,0,0, 0,2'd2, 6'd6,6'd1,5'd1, 0,0);  // 34
    add(1,0,0, 1,2'd0, 6'd6,6'd1,5'd1, 0,0);  // 35 mode edge on TC, TC dropped
    add(0,0,0, 1,2'd0, 6'd6,6'd1,5'd1, 0,0);  // 36
    add(1,0,0, 0,2'd0, 6'd6,6'd1,5'd1, 0,0);  // 37 back to CLOCK
    add(0,0,0, 0,2'd0, 6'd6,6'd1,5'd1, 0,0);  // 38
    add(1,0,1, 1,2'd0, 6'd6,6'd1,5'd1, 0,0);  // 39 mode + inc together
    add(0,0,0, 1,2'd0, 6'd6,6'd1,5'd1, 0,0);  // 40

    // Reset values, checked while reset is still asserted.
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_time", d),
            {o_hour[d], o_min[d], o_sec[d], o_pm[d]},
            {(d == 0) ? 5'd0 : 5'd12, 6'd0, 6'd0, 1'b0});
      check($sformatf("rst%0d_ctl", d),
            32'({o_mode[d], o_pos[d], o_stick[d], o_dtick[d]}), 32'd0);
    end
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      sw_mode[0] = vecs[i].m;
      sw_pos[0]  = vecs[i].p;
      sw_inc[0]  = vecs[i].i;
      tick();
      act = 32'({o_mode[0], o_pos[0], o_sec[0], o_min[0], o_hour[0], o_stick[0], o_dtick[0]});
      exp = 32'({vecs[i].em, vecs[i].ep, vecs[i].es, vecs[i].emin, vecs[i].eh,
                 vecs[i].est, vecs[i].edt});
      check($sformatf("vec%0d", i + 1), act, exp);
    end

    // Setup minute wrap without carry or ticks, then pos sequence.
    do_reset();
    press(0, 0, 1);
    press(0, 1, 1);
    check("setup_pos_min", 32'(o_pos[0]), 32'd1);
    press(0, 2, 59);
    check("setup_min59", 32'(o_min[0]), 32'd59);
    tick_seen[0] = 1'b0;
    press(0, 2, 3);
    check_time(0, "setup_minwrap", 0, 2, 0, 1'b0);
    check("setup_no_ticks", 32'(tick_seen[0]), 32'd0);
    press(0, 0, 2);
    check("setup_reentry_pos", 32'(o_pos[0]), 32'd0);
    press(0, 1, 1);
    check("pos_seq1", 32'(o_pos[0]), 32'd1);
    press(0, 1, 1);
    check("pos_seq2", 32'(o_pos[0]), 32'd2);
    press(0, 1, 1);
    check("pos_seq3", 32'(o_pos[0]), 32'd0);

    // Asynchronous reset mid-SETUP at 13:45:30, inc held through release.
    do_reset();
    press(0, 0, 1);
    press(0, 2, 30);
    press(0, 1, 1);
    press(0, 2, 45);
    press(0, 1, 1);
    press(0, 2, 13);
    check_time(0, "pre_rst", 13, 45, 30, 1'b0);
    check("pre_rst_mode", 32'(o_mode[0]), 32'd1);
    sw_inc[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_time(0, "async_rst", 0, 0, 0, 1'b0);
    check("async_rst_ctl", 32'({o_mode[0], o_pos[0], o_stick[0], o_dtick[0]}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tc_cyc = 0;
    for (int c = 1; c <= 8 && tc_cyc == 0; c++) begin
      tick();
      if (o_stick[0]) tc_cyc = c;
    end
    check("rst_first_tc_cycle", 32'(tc_cyc), 32'd4);
    check_time(0, "rst_inc_held", 0, 0, 1, 1'b0);
    sw_inc[0] = 1'b0;

    // 24-hour day rollover from 23:59:58.
    do_reset();
    press(0, 0, 1);
    press(0, 2, 58);
    press(0, 1, 1);
    press(0, 2, 59);
    press(0, 1, 1);
    press(0, 2, 23);
    check_time(0, "preset24", 23, 59, 58, 1'b0);
    press(0, 0, 1);
    wait_stick(0, "day24_s1");
    check_time(0, "day24_s1", 23, 59, 59, 1'b0);
    check("day24_s1_dtick", 32'(o_dtick[0]), 32'd0);
    wait_stick(0, "day24_s2");
    check_time(0, "day24_s2", 0, 0, 0, 1'b0);
    check("day24_dtick", 32'({o_stick[0], o_dtick[0]}), 32'd3);
    tick();
    check("day24_dtick_end", 32'({o_stick[0], o_dtick[0]}), 32'd0);

    // 12-hour: 11:59:59 AM -> 12:00:00 PM, then 11:59:59 PM -> 12:00:00 AM.
    do_reset();
    press(1, 0, 1);
    press(1, 2, 59);
    press(1, 1, 1);
    press(1, 2, 59);
    press(1, 1, 1);
    press(1, 2, 11);
    check_time(1, "preset_am", 11, 59, 59, 1'b0);
    press(1, 0, 1);
    wait_stick(1, "noon");
    check_time(1, "noon", 12, 0, 0, 1'b1);
    check("noon_dtick", 32'(o_dtick[1]), 32'd0);
    press(1, 0, 1);
    press(1, 1, 2);
    press(1, 2, 11);
    press(1, 1, 1);
    press(1, 2, 59);
    press(1, 1, 1);
    press(1, 2, 59);
    check_time(1, "preset_pm", 11, 59, 59, 1'b1);
    press(1, 0, 1);
    wait_stick(1, "midnight");
    check_time(1, "midnight", 12, 0, 0, 1'b0);
    check("midnight_dtick", 32'(o_dtick[1]), 32'd1);

    // Setup hour increment 11 -> 12 toggles PM without a day tick.
    press(1, 0, 1);
    press(1, 1, 2);
    press(1, 2, 11);
    tick_seen[1] = 1'b0;
    press(1, 2, 1);
    check("setup_hour12", 32'({o_hour[1], o_pm[1]}), 32'({5'd12, 1'b1}));
    check("setup_hour12_noticks", 32'(tick_seen[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
